// File: rtl/micro_store.sv
// micro_store: microcode ROM and MIR for the multicycle MIPS controller; stretches memory micro-ops until mem_ready.
// Optional wait-timeout fault enabled by defining MICRO_WAIT_TIMEOUT_EN.
module micro_store #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int WAIT_CNT_W   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic       mem_ready,
  output logic [3:0] mpc,
  output logic [1:0] next,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       fault
);
`ifdef MICRO_WAIT_TIMEOUT_EN
  typedef enum logic [1:0] {LOAD, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {LOAD, EXEC} state_t;
`endif
  if (2 ** WAIT_CNT_W <= WAIT_TIMEOUT) begin : g_bad_cnt_w
    $error("WAIT_CNT_W too narrow for WAIT_TIMEOUT");
  end
  // word: {pw, pwc, irw, rw, mr, mw, iod, m2r, asa, rdst, pc_source, alu_op, alu_src_b, next}
  function automatic logic [17:0] rom(input logic [3:0] a);
    case (a)
      4'd0:    rom = 18'b1010100000_00_00_01_11;
      4'd1:    rom = 18'b0000000000_00_00_11_01;
      4'd2:    rom = 18'b0000000010_00_00_10_10;
      4'd3:    rom = 18'b0000101000_00_00_00_11;
      4'd4:    rom = 18'b0001000100_00_00_00_00;
      4'd5:    rom = 18'b0000011000_00_00_00_00;
      4'd6:    rom = 18'b0000000010_00_10_00_11;
      4'd7:    rom = 18'b0001000001_00_00_00_00;
      4'd8:    rom = 18'b0100000010_01_01_00_00;
      4'd9:    rom = 18'b1000000000_10_00_00_00;
      default: rom = '0;
    endcase
  endfunction
  state_t      state_q;
  logic        boot_q;
  logic [17:0] mir_q, mir_d;
  logic [3:0]  mpc_q, mpc_d;
  logic        exec, done, strobe;
`ifdef MICRO_WAIT_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  fault_q;
`endif
  always_comb begin
    mpc_d  = boot_q ? 4'd0 : addr;
    mir_d  = rom(mpc_d);
    exec   = state_q == EXEC;
    done   = !(mir_q[13] | mir_q[12]) | mem_ready;
    strobe = exec & done;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD;
      boot_q  <= 1'b1;
      mir_q   <= '0;
      mpc_q   <= '0;
`ifdef MICRO_WAIT_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          mir_q   <= mir_d;
          mpc_q   <= mpc_d;
          boot_q  <= 1'b0;
          state_q <= EXEC;
        end
        EXEC: begin
          if (done) state_q <= LOAD;
`ifdef MICRO_WAIT_TIMEOUT_EN
          cnt_q <= done ? '0 : cnt_q + 1'b1;
          if (!done && cnt_q == WAIT_CNT_W'(WAIT_TIMEOUT - 1)) begin
            state_q <= HALT;
            mir_q   <= '0;
            mpc_q   <= '0;
            fault_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
  assign mpc           = mpc_q;
  assign next          = mir_q[1:0];
  assign pc_write      = strobe & mir_q[17];
  assign pc_write_cond = strobe & mir_q[16];
  assign ir_write      = strobe & mir_q[15];
  assign reg_write     = strobe & mir_q[14];
  assign mem_read      = exec & mir_q[13];
  assign mem_write     = exec & mir_q[12];
  assign i_or_d        = mir_q[11];
  assign mem_to_reg    = mir_q[10];
  assign alu_src_a     = mir_q[9];
  assign reg_dst       = mir_q[8];
  assign pc_source     = mir_q[7:6];
  assign alu_op        = mir_q[5:4];
  assign alu_src_b     = mir_q[3:2];
`ifdef MICRO_WAIT_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_micro_store.sv
// tb_micro_store: table-driven per-cycle vectors with an expected-value queue; bench models the next-address mux.
module tb_micro_store;
  typedef enum logic [2:0] {SKIP, BOOT, LD, EX, WT, HL} phase_t;
  typedef struct packed {
    logic [3:0] mpc;
    logic [1:0] nxt;
    logic pw, pwc, irw, rw, mr, mw, iod, m2r, asa, rd;
    logic [1:0] pcs, aop, asb;
    logic fault;
  } outs_t;
  typedef struct {
    bit rst;
    bit f9;
    bit mr;
    logic [5:0] op;
    logic [3:0] a;
    phase_t ph;
  } vec_t;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010;
  logic clock = 1'b0, reset = 1'b1, mem_ready = 1'b1, f9 = 1'b0;
  logic [5:0] op = RT;
  logic [3:0] addr, mux_q, mpc;
  logic [1:0] next, pc_source, alu_op, alu_src_b;
  logic pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic i_or_d, mem_to_reg, alu_src_a, reg_dst, fault;
  outs_t got;
  outs_t sb[$];
  vec_t tbl[$];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  micro_store #(.WAIT_TIMEOUT(4), .WAIT_CNT_W(8)) dut (
    .clock(clock), .reset(reset), .addr(addr), .mem_ready(mem_ready),
    .mpc(mpc), .next(next), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_b(alu_src_b), .fault(fault)
  );
  assign got = {mpc, next, pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                i_or_d, mem_to_reg, alu_src_a, reg_dst, pc_source, alu_op, alu_src_b, fault};
  function automatic logic [3:0] mux_f(input logic [3:0] m, input logic [1:0] n, input logic [5:0] o);
    case (n)
      2'b01:   mux_f = o == RT ? 4'd6 : (o == LW || o == SW) ? 4'd2 : o == BEQ ? 4'd8 : o == JMP ? 4'd9 : 4'd0;
      2'b10:   mux_f = o == LW ? 4'd3 : o == SW ? 4'd5 : 4'd0;
      2'b11:   mux_f = m + 4'd1;
      default: mux_f = 4'd0;
    endcase
  endfunction
  always_ff @(posedge clock) mux_q <= reset ? 4'd0 : mux_f(mpc, next, op);
  assign addr = f9 ? 4'd9 : mux_q;
  function automatic outs_t ucode(input logic [3:0] a);
    outs_t o;
    o = '0;
    case (a)
      4'd0: begin o.mr = 1; o.irw = 1; o.asb = 2'b01; o.pw = 1; o.nxt = 2'b11; end
      4'd1: begin o.asb = 2'b11; o.nxt = 2'b01; end
      4'd2: begin o.asa = 1; o.asb = 2'b10; o.nxt = 2'b10; end
      4'd3: begin o.mr = 1; o.iod = 1; o.nxt = 2'b11; end
      4'd4: begin o.rw = 1; o.m2r = 1; end
      4'd5: begin o.mw = 1; o.iod = 1; end
      4'd6: begin o.asa = 1; o.aop = 2'b10; o.nxt = 2'b11; end
      4'd7: begin o.rd = 1; o.rw = 1; end
      4'd8: begin o.asa = 1; o.aop = 2'b01; o.pwc = 1; o.pcs = 2'b01; end
      4'd9: begin o.pw = 1; o.pcs = 2'b10; end
      default: ;
    endcase
    o.mpc = a;
    return o;
  endfunction
  function automatic outs_t model(input logic [3:0] a, input phase_t ph);
    outs_t o;
    o = ucode(a);
    if (ph == LD || ph == WT) begin o.pw = 0; o.pwc = 0; o.irw = 0; o.rw = 0; end
    if (ph == LD) begin o.mr = 0; o.mw = 0; end
    if (ph == BOOT || ph == HL) o = '0;
    if (ph == HL) o.fault = 1;
    return o;
  endfunction
  task automatic add(input bit rst, input bit fr, input bit mr, input logic [5:0] o, input logic [3:0] a, input phase_t ph);
    vec_t v;
    v.rst = rst; v.f9 = fr; v.mr = mr; v.op = o; v.a = a; v.ph = ph;
    tbl.push_back(v);
  endtask
  task automatic mi(input logic [5:0] o, input logic [3:0] a);
    add(0, 0, 1, o, a, EX);
    add(0, 0, 1, o, a, LD);
  endtask
  task automatic rs(input logic [5:0] o);
    add(1, 0, 1, o, 0, SKIP);
    add(1, 0, 1, o, 0, SKIP);
    add(0, 0, 1, o, 0, BOOT);
  endtask
  task automatic step(input vec_t v, input int idx);
    outs_t e;
    @(posedge clock);
    #1;
    reset = v.rst; f9 = v.f9; mem_ready = v.mr; op = v.op;
    if (v.ph != SKIP) sb.push_back(model(v.a, v.ph));
    @(negedge clock);
    if (v.ph != SKIP) begin
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL vec%0d %s mpc=%0d: got=%h expected=%h", idx, v.ph.name(), v.a, got, e);
      end
    end
  endtask
  initial begin
    rs(RT); mi(RT, 0); mi(RT, 1); mi(RT, 6); mi(RT, 7); add(0, 0, 1, RT, 0, EX);
    rs(LW); mi(LW, 0); mi(LW, 1);
    add(0, 0, 0, LW, 2, EX); add(0, 0, 0, LW, 2, LD);
    repeat (3) add(0, 0, 0, LW, 3, WT);
    mi(LW, 3); mi(LW, 4); add(0, 0, 1, LW, 0, EX);
    rs(SW); mi(SW, 0); mi(SW, 1); mi(SW, 2); mi(SW, 5); add(0, 0, 1, SW, 0, EX);
    rs(BEQ); mi(BEQ, 0); mi(BEQ, 1); mi(BEQ, 8); add(0, 0, 1, BEQ, 0, EX);
    rs(JMP); mi(JMP, 0); mi(JMP, 1); mi(JMP, 9); add(0, 0, 1, JMP, 0, EX);
    rs(LW); mi(LW, 0); mi(LW, 1); mi(LW, 2);
    repeat (2) add(0, 0, 0, LW, 3, WT);
    add(1, 1, 0, LW, 3, WT);
    add(0, 1, 1, LW, 0, BOOT);
    mi(LW, 0); add(0, 0, 1, LW, 1, EX);
    foreach (tbl[i]) step(tbl[i], i);
    // stuck-memory sequence at the fetch micro-op
    tbl.delete();
    rs(RT);
    repeat (4) add(0, 0, 0, RT, 0, WT);
`ifdef MICRO_WAIT_TIMEOUT_EN
    repeat (3) add(0, 0, 1, RT, 0, HL);
    rs(RT);
`else
    repeat (4) add(0, 0, 0, RT, 0, WT);
`endif
    mi(RT, 0); add(0, 0, 1, RT, 1, EX);
    foreach (tbl[i]) step(tbl[i], 1000 + i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
